// File: rtl/eth_stream_arbiter.sv
// eth_stream_arbiter: round-robin arbiter that merges NUM_SRC capture
// sources into one AXI-Stream. A granted source keeps the grant until its
// frame ends (src_in_progress low at accept) or the frame reaches MAX_BEATS,
// in which case the frame is cut, tlast is forced and frame_trunc sticks.
// Output beats are registered with a single-entry skid-free output stage
// that still sustains one beat per cycle under tready=1.
module eth_stream_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_SRC    = 5,
  parameter int MAX_BEATS  = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_in_progress,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [2:0]                    m_axis_tuser,
  output logic                          frame_trunc
);

  localparam int              CW       = $clog2(MAX_BEATS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_BEATS - 1);
  localparam logic [2:0]      SRC_LAST = 3'(NUM_SRC - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  // Reset synchronizer and core reset
  logic [1:0]            rst_sync_q;
  logic                  rst_core_s;

  // FSM and arbitration state
  state_e                state_q, state_d;
  logic [2:0]            g_q, g_d;
  logic [2:0]            p_q, p_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Output register
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic [2:0]            tuser_q;
  logic                  trunc_q;

  // Combinational helpers
  logic [DATA_WIDTH-1:0] data_arr_s [NUM_SRC];
  logic                  sel_found_s;
  logic [2:0]            sel_idx_s;
  logic [3:0]            idx_v;
  logic                  hit_v;
  logic                  rdy_s;
  logic                  accept_s;
  logic                  last_s;
  logic                  trunc_s;

  // Unpack the flat source data bus into one word per source.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign data_arr_s[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Assertion is immediate; release is delayed two edges so the core never
  // sees a reset removal close to an active edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_core_s = rst_sync_q[1];

  // Output stage can take a new beat when it is empty or being drained.
  assign rdy_s = m_axis_tready | ~tvalid_q;

  // Round-robin search: first valid source starting from pointer p.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = 3'd0;
    idx_v       = 4'd0;
    hit_v       = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx_v       = {1'b0, p_q} + 4'(k);
      idx_v       = (idx_v >= 4'(NUM_SRC)) ? (idx_v - 4'(NUM_SRC)) : idx_v;
      hit_v       = src_valid[idx_v[2:0]] & ~sel_found_s;
      sel_idx_s   = hit_v ? idx_v[2:0] : sel_idx_s;
      sel_found_s = sel_found_s | hit_v;
    end
  end

  // FSM next state, grant/pointer/counter update and per-source ready.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    src_ready = '0;
    accept_s  = 1'b0;
    last_s    = 1'b0;
    trunc_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found_s) begin
          state_d = GRANT;
          g_d     = sel_idx_s;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        src_ready[g_q] = rdy_s;
        accept_s       = src_valid[g_q] & rdy_s;
        if (accept_s) begin
          cnt_d = cnt_q + CW'(1);
          if (!src_in_progress[g_q]) begin
            last_s = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            // Frame hit the length cap: cut it here, remainder re-arbitrates.
            last_s  = 1'b1;
            trunc_s = 1'b1;
          end else begin
            last_s = 1'b0;
          end
          if (last_s) begin
            state_d = IDLE;
            p_d     = (g_q == SRC_LAST) ? 3'd0 : (g_q + 3'd1);
          end else begin
            state_d = GRANT;
          end
        end else begin
          // Source bubble: keep the grant, no timeout.
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, grant, pointer and beat-counter registers.
  always_ff @(posedge clk or posedge rst_core_s) begin
    if (rst_core_s) begin
      state_q <= IDLE;
      g_q     <= 3'd0;
      p_q     <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output beat register: load on accept, drop valid once drained.
  always_ff @(posedge clk or posedge rst_core_s) begin
    if (rst_core_s) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 3'd0;
      trunc_q  <= 1'b0;
    end else begin
      if (accept_s) begin
        tdata_q  <= data_arr_s[g_q];
        tuser_q  <= g_q;
        tlast_q  <= last_s;
        tvalid_q <= 1'b1;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
      end else begin
        tvalid_q <= tvalid_q;
      end
      trunc_q <= trunc_q | trunc_s;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_trunc   = trunc_q;

endmodule

// File: doc/eth_stream_arbiter.md
ETH_STREAM_ARBITER -- requirements
Module: eth_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, width of each source data word and of m_axis_tdata.
REQ-002 SHALL have parameter NUM_SRC, default 5, number of capture submodules arbitrated (AW, W, B, AR, R), legal range 2..8.
REQ-003 SHALL have parameter MAX_BEATS, default 256, maximum beats per output frame, power of two, at least 2.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL provide clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL provide reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL provide src_valid  input  NUM_SRC  bit i high: source i has a valid word.
REQ-008 SHALL provide src_in_progress  input  NUM_SRC  bit i high: source i has further words in the current frame.
REQ-009 SHALL provide src_data  input  NUM_SRC*DATA_WIDTH  slice i is source i's word.
REQ-010 SHALL provide src_ready  output  NUM_SRC  per-source ready, at most one bit high.
REQ-011 SHALL provide m_axis_tdata  output  DATA_WIDTH  stream data.
REQ-012 SHALL provide m_axis_tvalid  output  1; m_axis_tready  input  1; m_axis_tlast  output  1.
REQ-013 SHALL provide m_axis_tuser  output  3  index of the source that produced the beat.
REQ-014 SHALL provide frame_trunc  output  1  sticky flag, set when a frame was cut at MAX_BEATS.

Function
REQ-015 SHALL implement FSM states IDLE and GRANT, plus grant index g and round-robin pointer p.
REQ-016 In IDLE: SHALL select the first i with src_valid[i]=1, searching p, p+1, ... modulo NUM_SRC; it SHALL load g=i and enter GRANT on the next edge; with no valid source it SHALL stay in IDLE.
REQ-017 In IDLE: SHALL hold all src_ready low.
REQ-018 In GRANT: src_ready[g] SHALL equal (m_axis_tready OR NOT m_axis_tvalid), combinationally; all other src_ready bits SHALL be 0.
REQ-019 Beat accept: a beat is accepted when src_valid[g] AND src_ready[g].
REQ-020 On accept: SHALL register src_data slice g into m_axis_tdata, g into m_axis_tuser, and set m_axis_tvalid=1; latency is 1 cycle.
REQ-021 Output register: m_axis_tvalid, tdata, tlast and tuser SHALL hold stable while tvalid=1 and tready=0.
REQ-022 When tready=1 with no new accept, m_axis_tvalid SHALL clear on the next edge.
REQ-023 A simultaneous drain and accept SHALL sustain 1 beat per cycle.
REQ-024 Frame end: m_axis_tlast SHALL be set on the accepted beat when src_in_progress[g]=0 at accept.
REQ-025 On frame end: the FSM SHALL return to IDLE and set p=(g+1) mod NUM_SRC.
REQ-026 Idle gaps: src_valid[g]=0 in GRANT inserts bubbles indefinitely; the grant SHALL be kept, with no timeout.
REQ-027 Beat counter: SHALL be log2(MAX_BEATS) bits wide, cleared on entry to GRANT and incremented per accept.
REQ-028 When an accepted beat is beat number MAX_BEATS and src_in_progress[g]=1: SHALL force tlast=1, set frame_trunc, and release to IDLE with p=g+1.
REQ-029 After truncation, the source's remaining words SHALL form a new frame at a later grant.
REQ-030 Between frames there SHALL be exactly one IDLE arbitration cycle with all src_ready low.
REQ-031 frame_trunc SHALL clear only on reset.
REQ-032 Source-side timing: src_valid and src_in_progress may change in any cycle; only their values at accept are used.
REQ-033 In GRANT, src_valid of non-granted sources SHALL be ignored.

Reset
REQ-034 While reset=1: src_ready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, frame_trunc=0, state=IDLE, p=0, g=0, beat counter=0.
REQ-035 A reset asserted mid-frame SHALL discard the pending output beat; after release, arbitration SHALL restart from source 0.
REQ-036 Reset deassertion SHALL be synchronized internally so the first active edge is clean.

Verification
REQ-037 Single frame: source 2 sends 3 words A,B,C with in_progress 1,1,0 and tready=1 -> 3 output beats A,B,C back-to-back, tuser=2, tlast only on C, first beat 2 cycles after src_valid rises.
REQ-038 Round robin: sources 0 and 3 each continuously offer 1-word frames -> output tuser sequence 0,3,0,3 with one bubble cycle between frames.
REQ-039 Backpressure: tready low for 4 cycles mid-frame -> tdata/tvalid/tuser stable, src_ready low, no beat lost or duplicated, order preserved.
REQ-040 Truncation, with MAX_BEATS=4: source 1 sends a 6-word frame -> beats 1..4 with tlast on beat 4 and frame_trunc=1, then beats 5..6 as a second frame with tlast on beat 6.
REQ-041 Reset mid-frame: assert reset after beat 2 of 5 -> all outputs 0 immediately; after release, a source 4 request is granted and the frame is output with tuser=4.
REQ-042 Source stall: src_valid[g] low for 10 cycles while in_progress=1, with source 0 also valid -> grant is retained, no source-0 beat is interleaved, and the frame completes with correct tlast.
